// File: rtl/mem_arbiter.sv
// mem_arbiter: upstream arbiter for the external SPI memory controller.
// Accepts rv32e instruction-fetch and data load/store requests, serves one at
// a time (data has fixed priority over fetch) and drives the controller's
// start_request / request_done level handshake.
//
// Ports:
//   clk, rst_n             clock; asynchronous active-low reset
//   ifetch_req/addr        fetch request (held until ifetch_done)
//   ifetch_data/done       fetched word; one-cycle completion pulse
//   data_req/addr/we/size/unsigned/wdata
//                          load/store request (held until data_done)
//   data_rdata/done        sized and extended load result (0 after stores);
//                          one-cycle completion pulse
//   mem_*                  request interface to the SPI memory controller
//   err                    watchdog timeout pulse, coincident with done
//
// Build option: MEM_ARB_TIMEOUT_EN adds a watchdog that aborts a transaction
// after TIMEOUT_CYCLES cycles in ISSUE. Without it err is constant 0.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifetch_req,
  input  logic [24:0] ifetch_addr,
  output logic [31:0] ifetch_data,
  output logic        ifetch_done,
  input  logic        data_req,
  input  logic [24:0] data_addr,
  input  logic        data_we,
  input  logic [1:0]  data_size,
  input  logic        data_unsigned,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  output logic [24:0] mem_target_address,
  output logic [2:0]  mem_num_bytes,
  output logic        mem_is_write,
  output logic [31:0] mem_write_value,
  output logic        mem_start_request,
  input  logic        mem_request_done,
  input  logic [31:0] mem_fetched_value,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [24:0] addr_q, addr_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic        is_write_q, is_write_d;
  logic [31:0] wval_q, wval_d;
  logic        start_q, start_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] ifetch_data_q, ifetch_data_d;
  logic        ifetch_done_q, ifetch_done_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        data_done_q, data_done_d;
  logic [31:0] load_ext;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  function automatic logic [2:0] size_to_bytes(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Controller returns little-endian, right-aligned bytes; extend from the
  // top valid bit of the latched access size.
  always_comb begin
    case (size_q)
      2'd0:    load_ext = {{24{~uns_q & mem_fetched_value[7]}},  mem_fetched_value[7:0]};
      2'd1:    load_ext = {{16{~uns_q & mem_fetched_value[15]}}, mem_fetched_value[15:0]};
      default: load_ext = mem_fetched_value;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    nbytes_d      = nbytes_q;
    is_write_d    = is_write_q;
    wval_d        = wval_q;
    start_d       = start_q;
    size_d        = size_q;
    uns_d         = uns_q;
    ifetch_data_d = ifetch_data_q;
    data_rdata_d  = data_rdata_q;
    ifetch_done_d = 1'b0;
    data_done_d   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    err_d         = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (data_req) begin
          owner_d    = OWN_DATA;
          addr_d     = data_addr;
          nbytes_d   = size_to_bytes(data_size);
          is_write_d = data_we;
          wval_d     = data_wdata;
          size_d     = data_size;
          uns_d      = data_unsigned;
          start_d    = 1'b1;
          state_d    = ISSUE;
        end else if (ifetch_req) begin
          owner_d    = OWN_FETCH;
          addr_d     = ifetch_addr;
          nbytes_d   = 3'd4;
          is_write_d = 1'b0;
          wval_d     = '0;
          size_d     = 2'd2;
          uns_d      = 1'b1;
          start_d    = 1'b1;
          state_d    = ISSUE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        if (data_req || ifetch_req) cnt_d = '0;
`endif
      end
      ISSUE: begin
        if (mem_request_done) begin
          start_d = 1'b0;
          state_d = RELEASE;
          if (owner_q == OWN_DATA) begin
            data_done_d  = 1'b1;
            data_rdata_d = is_write_q ? '0 : load_ext;
          end else begin
            ifetch_done_d = 1'b1;
            ifetch_data_d = mem_fetched_value;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // cnt_q counts completed ISSUE cycles; abort on the edge that would
        // make it reach TIMEOUT_CYCLES.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          start_d = 1'b0;
          state_d = RELEASE;
          err_d   = 1'b1;
          if (owner_q == OWN_DATA) begin
            data_done_d  = 1'b1;
            data_rdata_d = '1;
          end else begin
            ifetch_done_d = 1'b1;
            ifetch_data_d = '1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= OWN_FETCH;
      addr_q        <= '0;
      nbytes_q      <= '0;
      is_write_q    <= 1'b0;
      wval_q        <= '0;
      start_q       <= 1'b0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      ifetch_data_q <= '0;
      ifetch_done_q <= 1'b0;
      data_rdata_q  <= '0;
      data_done_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      addr_q        <= addr_d;
      nbytes_q      <= nbytes_d;
      is_write_q    <= is_write_d;
      wval_q        <= wval_d;
      start_q       <= start_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      ifetch_data_q <= ifetch_data_d;
      ifetch_done_q <= ifetch_done_d;
      data_rdata_q  <= data_rdata_d;
      data_done_q   <= data_done_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      err_q         <= err_d;
`endif
    end
  end

  assign mem_target_address = addr_q;
  assign mem_num_bytes      = nbytes_q;
  assign mem_is_write       = is_write_q;
  assign mem_write_value    = wval_q;
  assign mem_start_request  = start_q;
  assign ifetch_data        = ifetch_data_q;
  assign ifetch_done        = ifetch_done_q;
  assign data_rdata         = data_rdata_q;
  assign data_done          = data_done_q;

`ifdef MEM_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  // Watchdog absent: err is constant 0; the parameter is referenced only so
  // it is not reported as dangling in this build.
  assign err = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Upstream stage of the external SPI memory controller; the sole driver of its request interface.
- Accepts instruction-fetch and data load/store requests from the rv32e core.
- Arbitrates between them and sequences the controller's start_request/request_done level handshake.
- Returns fetched words, or load data sized and sign/zero-extended.

Parameters:
TIMEOUT_CYCLES, 255, watchdog limit in clk cycles (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
ifetch_req  input  1  fetch request; held high until ifetch_done
ifetch_addr  input  25  fetch address; bit 24 selects RAM(1) or flash(0)
ifetch_data  output  32  fetched instruction word
ifetch_done  output  1  one-cycle completion pulse
data_req  input  1  load/store request; held high until data_done
data_addr  input  25  load/store address
data_we  input  1  1 = store
data_size  input  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
data_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
data_wdata  input  32  store data, right-aligned
data_rdata  output  32  extended load result; 0 after stores
data_done  output  1  one-cycle completion pulse
mem_target_address  output  25  to controller
mem_num_bytes  output  3  to controller: 1, 2 or 4
mem_is_write  output  1  to controller
mem_write_value  output  32  to controller
mem_start_request  output  1  to controller; level
mem_request_done  input  1  from controller
mem_fetched_value  input  32  from controller; little-endian, right-aligned
err  output  1  timeout flag pulse (constant 0 without macro)

Behaviour:
- Reset values (async, rst_n low): state IDLE; every output register 0, including mem_start_request, dones, rdata/data and err.
- States: IDLE, ISSUE, RELEASE.
- IDLE:
  - At a posedge with data_req=1, or ifetch_req=1, latch the winner's address/size/we/wdata into mem_* registers.
  - Set mem_start_request=1, record the owner, go to ISSUE.
  - Fixed priority: data over ifetch when both are high at the same edge.
- ISSUE:
  - mem_* outputs stable; request inputs are ignored.
  - At a posedge with mem_request_done=1:
    - set mem_start_request=0;
    - capture the result into the owner's data register;
    - pulse the owner's done for exactly one cycle;
    - go to RELEASE.
- RELEASE:
  - Exactly one cycle with mem_start_request low; this guarantees the controller's negedge return to its idle state.
  - Then IDLE.
  - A request still high at the RELEASE→IDLE edge is not sampled.
  - The earliest next issue is the edge after entering IDLE.
  - Minimum start_request low time between transactions: 2 cycles.
- Latency: request sampled at edge N → mem_start_request high after N; done high in the cycle following the edge that samples mem_request_done.
- Size mapping: size 0→num_bytes 1, 1→2, 2/3→4. Fetches always use 4.
- Load extension:
  - byte: bits[7:0], with bits[31:8] = data_unsigned ? 0 : replicated bit 7;
  - half: same rule from bit 15;
  - word: unchanged.
  - Stores return data_rdata=0.
- Misaligned addresses pass through unmodified; the SPI devices are byte-addressed.
- Requester drops req mid-ISSUE: the transaction still completes and done still pulses.
- Async reset mid-ISSUE: mem_start_request drops immediately; no done is issued; the controller self-aborts on start_request low.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - An 8+-bit counter clears on entering ISSUE and increments each ISSUE cycle.
  - When it reaches TIMEOUT_CYCLES without mem_request_done: abort exactly like completion (start low, RELEASE), pulse the owner's done, set the owner's data to 32'hFFFFFFFF, and pulse err with done.
- Undefined: no counter; ISSUE waits indefinitely; err tied 0.

Test Plan:
- Fetch: ifetch_req, addr 0x000100; model returns 0x00000013 → mem_num_bytes=4, mem_is_write=0, mem_target_address=0x000100, ifetch_data=0x00000013, ifetch_done for 1 cycle, start low ≥2 cycles afterwards.
- Signed byte load: data_size=0, unsigned=0, addr 0x1000010; fetched 0x00000080 → num_bytes=1, data_rdata=0xFFFFFF80. Repeat with unsigned=1 → 0x00000080.
- Half store: data_we=1, size=1, wdata 0x0000BEEF, addr 0x1000020 → mem_is_write=1, num_bytes=2, mem_write_value=0x0000BEEF, data_rdata=0, data_done pulse.
- Contention: data_req and ifetch_req rise on the same edge → data served first; fetch issued 2 cycles after data_done; exactly one done pulse each.
- Reset: assert rst_n low during ISSUE → mem_start_request=0 asynchronously, no done. After release, a new fetch completes normally.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20, controller never completes → at cycle 20 ifetch_done=1, err=1, ifetch_data=0xFFFFFFFF, state returns to IDLE.
